// File: rtl/irda_fir_flag_seq_pkg.sv
// Shared flag codes, chip patterns and sequencer states for the FIR flag path.
// Patterns are stored with chip 0 in the MSB.
package irda_flag_pkg;

  typedef enum logic [1:0] {
    FLAG_NONE = 2'b00,
    FLAG_PA   = 2'b01,
    FLAG_STA  = 2'b10,
    FLAG_STO  = 2'b11
  } flag_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [15:0] PA_PATTERN  = 16'b1000_0000_1010_1000;
  localparam logic [31:0] STA_PATTERN = 32'h0C0C_6060;
  localparam logic [31:0] STO_PATTERN = 32'h0C0C_0606;

endpackage

// File: rtl/irda_fir_flag_seq_if.sv
// Handshake and chip-output bundle between the framing controller and the flag sequencer.
interface irda_fir_flag_seq_if #(
  parameter int unsigned CHIPS_W = 1,
  parameter int unsigned REPS_W  = 5
) ();
  logic               chip_en;
  logic               start;
  logic [1:0]         flag_sel;
  logic [REPS_W-1:0]  pa_reps;
  logic               abort;
  logic               busy;
  logic [CHIPS_W-1:0] chips_o;
  logic               chip_stb;
  logic               eof;

  modport master (
    output chip_en, start, flag_sel, pa_reps, abort,
    input  busy, chips_o, chip_stb, eof
  );

  modport slave (
    input  chip_en, start, flag_sel, pa_reps, abort,
    output busy, chips_o, chip_stb, eof
  );
endinterface

// File: rtl/irda_fir_flag_seq_chip_rom.sv
// Combinational pattern lookup: returns CHIPS_W chips starting at idx, earliest chip in the MSB.
module irda_flag_chip_rom
  import irda_flag_pkg::*;
#(
  parameter int unsigned CHIPS_W = 1
) (
  input  flag_e              flag,
  input  logic [4:0]         idx,
  output logic [CHIPS_W-1:0] chips
);

  logic [31:0] pat;
  logic [4:0]  pos;

  always_comb begin
    pat = '0;
    case (flag)
      FLAG_PA:  pat = {PA_PATTERN, PA_PATTERN};
      FLAG_STA: pat = STA_PATTERN;
      FLAG_STO: pat = STO_PATTERN;
      default:  pat = '0;
    endcase
  end

  // Chip k lives at bit 31-k, which for a 5-bit position is simply ~pos.
  always_comb begin
    chips = '0;
    pos   = '0;
    for (int unsigned i = 0; i < CHIPS_W; i++) begin
      pos                 = idx + 5'(i);
      chips[CHIPS_W-1-i]  = pat[~pos];
    end
  end

endmodule

// File: rtl/irda_fir_flag_seq.sv
// FIR flag sequencer: emits PA (repeated), STA or STO chip groups on chip_en with
// a start/busy/eof handshake and synchronous abort.
module irda_fir_flag_seq
  import irda_flag_pkg::*;
#(
  parameter int unsigned CHIPS_W = 1,
  parameter int unsigned REPS_W  = 5
) (
  input  logic              clk,
  input  logic              wb_rst_i,
  irda_fir_flag_seq_if.slave bus
);

  localparam logic [5:0] STEP = 6'(CHIPS_W);

  state_e             state_q, state_d;
  flag_e              flag_q, flag_d;
  logic [REPS_W-1:0]  reps_q, reps_d;
  logic [REPS_W-1:0]  rep_q, rep_d;
  logic [4:0]         idx_q, idx_d;
  logic [CHIPS_W-1:0] chips_q, chips_d;
  logic               stb_q, stb_d;
  logic               eof_q, eof_d;
  logic               busy_q, busy_d;

  logic [CHIPS_W-1:0] rom_chips;
  logic [5:0]         idx_sum;
  logic [REPS_W-1:0]  rep_inc;
  logic               final_grp;

  irda_flag_chip_rom #(.CHIPS_W(CHIPS_W)) u_rom (
    .flag  (flag_q),
    .idx   (idx_q),
    .chips (rom_chips)
  );

  assign idx_sum = {1'b0, idx_q} + STEP;
  assign rep_inc = rep_q + REPS_W'(1);

  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    reps_d    = reps_q;
    rep_d     = rep_q;
    idx_d     = idx_q;
    chips_d   = chips_q;
    stb_d     = 1'b0;
    eof_d     = 1'b0;
    busy_d    = busy_q;
    final_grp = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      chips_d = '0;
      idx_d   = '0;
      rep_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.chip_en) chips_d = '0;
          if (bus.start && (bus.flag_sel != FLAG_NONE)) begin
            state_d = RUN;
            busy_d  = 1'b1;
            flag_d  = flag_e'(bus.flag_sel);
            reps_d  = (bus.pa_reps == '0) ? REPS_W'(1) : bus.pa_reps;
            idx_d   = '0;
            rep_d   = '0;
          end
        end
        RUN: begin
          if (bus.chip_en) begin
            chips_d = rom_chips;
            stb_d   = 1'b1;
            idx_d   = idx_sum[4:0];
            // PA wraps every 16 chips and counts repetitions; STA/STO end at chip 31.
            if (flag_q == FLAG_PA) begin
              if (idx_sum[4]) begin
                idx_d     = '0;
                rep_d     = rep_inc;
                final_grp = (rep_inc == reps_q);
              end
            end else begin
              final_grp = idx_sum[5];
            end
            if (final_grp) begin
              eof_d   = 1'b1;
              state_d = IDLE;
              busy_d  = 1'b0;
              idx_d   = '0;
              rep_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      flag_q  <= FLAG_NONE;
      reps_q  <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      chips_q <= '0;
      stb_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      reps_q  <= reps_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      chips_q <= chips_d;
      stb_q   <= stb_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.chips_o  = chips_q;
  assign bus.chip_stb = stb_q;
  assign bus.eof      = eof_q;

endmodule

// File: tb/tb_irda_fir_flag_seq.sv
// Directed bench driving CHIPS_W=1 and CHIPS_W=4 sequencers with identical stimulus.
module tb_irda_fir_flag_seq;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       chip_en, start, abort;
  logic [1:0] flag_sel;
  logic [4:0] pa_reps;

  always #5 clk = ~clk;

  irda_fir_flag_seq_if #(.CHIPS_W(1), .REPS_W(5)) bus1 ();
  irda_fir_flag_seq_if #(.CHIPS_W(4), .REPS_W(5)) bus4 ();

  assign bus1.chip_en  = chip_en;
  assign bus1.start    = start;
  assign bus1.flag_sel = flag_sel;
  assign bus1.pa_reps  = pa_reps;
  assign bus1.abort    = abort;
  assign bus4.chip_en  = chip_en;
  assign bus4.start    = start;
  assign bus4.flag_sel = flag_sel;
  assign bus4.pa_reps  = pa_reps;
  assign bus4.abort    = abort;

  irda_fir_flag_seq #(.CHIPS_W(1), .REPS_W(5)) u_dut1 (
    .clk(clk), .wb_rst_i(wb_rst_i), .bus(bus1)
  );
  irda_fir_flag_seq #(.CHIPS_W(4), .REPS_W(5)) u_dut4 (
    .clk(clk), .wb_rst_i(wb_rst_i), .bus(bus4)
  );

  typedef struct {
    logic [1:0]  flag_sel;
    logic [4:0]  pa_reps;
    bit          start_on_en;
    logic [31:0] pat;
    int          len;
    int          reps;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic       q1[$];
  logic [3:0] q4[$];
  int         t4[$];
  int         eof1_n, eof4_n, eof1_pos, eof4_last, eof_bad;
  int         en_ticks = 0;

  always @(posedge clk) if (chip_en) en_ticks++;

  always @(negedge clk) begin
    if (bus1.chip_stb) q1.push_back(bus1.chips_o[0]);
    if (bus1.eof) begin
      eof1_n++;
      eof1_pos = q1.size();
      if (bus1.busy || !bus1.chip_stb) eof_bad++;
    end
    if (bus4.chip_stb) begin
      q4.push_back(bus4.chips_o);
      t4.push_back(en_ticks);
    end
    if (bus4.eof) begin
      eof4_n++;
      eof4_last = q4.size();
      if (bus4.busy || !bus4.chip_stb) eof_bad++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic en_tick();
    chip_en = 1'b1;
    tick();
    chip_en = 1'b0;
    tick();
  endtask

  task automatic clear_mon();
    q1.delete();
    q4.delete();
    t4.delete();
    eof1_n    = 0;
    eof4_n    = 0;
    eof1_pos  = 0;
    eof4_last = 0;
    eof_bad   = 0;
  endtask

  task automatic run_vec(input int r, input vec_t v);
    int          n1, n4, mism1, gpr;
    logic [31:0] p;
    logic        expb;
    clear_mon();
    flag_sel = v.flag_sel;
    pa_reps  = v.pa_reps;
    start    = 1'b1;
    chip_en  = v.start_on_en;
    tick();
    start    = 1'b0;
    chip_en  = 1'b0;
    flag_sel = ~v.flag_sel;
    pa_reps  = 5'd7;
    expb     = (v.flag_sel != 2'b00);
    chk($sformatf("v%0d_busy_rise1", r), 32'(bus1.busy), 32'(expb));
    chk($sformatf("v%0d_busy_rise4", r), 32'(bus4.busy), 32'(expb));
    if (v.start_on_en) begin
      chk($sformatf("v%0d_en_start_out4", r), {27'd0, bus4.chip_stb, bus4.chips_o}, 32'd0);
    end
    for (int k = 0; k < 600; k++) begin
      if (!bus1.busy && !bus4.busy) break;
      en_tick();
    end
    chk($sformatf("v%0d_timeout", r), 32'(bus1.busy | bus4.busy), 32'd0);
    en_tick();
    en_tick();
    n1 = v.len * v.reps;
    n4 = n1 / 4;
    chk($sformatf("v%0d_strobes1", r), 32'(q1.size()), 32'(n1));
    chk($sformatf("v%0d_strobes4", r), 32'(q4.size()), 32'(n4));
    chk($sformatf("v%0d_eofs1", r), 32'(eof1_n), 32'(n1 > 0));
    chk($sformatf("v%0d_eofs4", r), 32'(eof4_n), 32'(n4 > 0));
    chk($sformatf("v%0d_eofpos1", r), 32'(eof1_pos), 32'(n1));
    chk($sformatf("v%0d_eofpos4", r), 32'(eof4_last), 32'(n4));
    chk($sformatf("v%0d_eof_busy", r), 32'(eof_bad), 32'd0);
    if (v.len > 0) begin
      p     = v.pat;
      mism1 = 0;
      for (int i = 0; i < q1.size(); i++)
        if (q1[i] !== p[31 - (i % v.len)]) mism1++;
      chk($sformatf("v%0d_data1_bad_chips", r), 32'(mism1), 32'd0);
      gpr = v.len / 4;
      for (int g = 0; g < q4.size(); g++)
        chk($sformatf("v%0d_data4_g%0d", r, g), 32'(q4[g]), 32'(4'(p >> (28 - 4 * (g % gpr)))));
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [63:0] exp_b2b;
    logic [31:0] sta;
    bit          sto_sent;
    int          mism;

    vecs[0] = '{2'b01, 5'd1,  1'b0, 32'h80A8_0000, 16, 1};
    vecs[1] = '{2'b01, 5'd0,  1'b0, 32'h80A8_0000, 16, 1};
    vecs[2] = '{2'b01, 5'd3,  1'b1, 32'h80A8_0000, 16, 3};
    vecs[3] = '{2'b10, 5'd0,  1'b0, 32'h0C0C_6060, 32, 1};
    vecs[4] = '{2'b11, 5'd9,  1'b1, 32'h0C0C_0606, 32, 1};
    vecs[5] = '{2'b00, 5'd4,  1'b0, 32'h0000_0000, 0,  0};
    vecs[6] = '{2'b01, 5'd16, 1'b0, 32'h80A8_0000, 16, 16};

    chip_en  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    flag_sel = 2'b00;
    pa_reps  = 5'd0;
    wb_rst_i = 1'b1;
    repeat (3) tick();
    chk("reset_out1", {28'd0, bus1.busy, bus1.chip_stb, bus1.eof, bus1.chips_o}, 32'd0);
    chk("reset_out4", {25'd0, bus4.busy, bus4.chip_stb, bus4.eof, bus4.chips_o}, 32'd0);
    wb_rst_i = 1'b0;
    tick();

    for (int r = 0; r < 7; r++) run_vec(r, vecs[r]);

    // Back-to-back STA then STO, second start issued in the eof cycle of the 4-chip unit.
    clear_mon();
    flag_sel = 2'b10;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    sto_sent = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!bus1.busy && !bus4.busy) break;
      chip_en = 1'b1;
      tick();
      chip_en = 1'b0;
      if (bus4.eof && !sto_sent) begin
        start    = 1'b1;
        flag_sel = 2'b11;
        sto_sent = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("b2b_timeout", 32'(bus1.busy | bus4.busy), 32'd0);
    en_tick();
    exp_b2b = 64'h0C0C_6060_0C0C_0606;
    chk("b2b_strobes4", 32'(q4.size()), 32'd16);
    for (int g = 0; g < 16 && g < q4.size(); g++)
      chk($sformatf("b2b_data4_g%0d", g), 32'(q4[g]), 32'(4'(exp_b2b >> (60 - 4 * g))));
    chk("b2b_eofs4", 32'(eof4_n), 32'd2);
    chk("b2b_eofpos4", 32'(eof4_last), 32'd16);
    if (q4.size() == 16) chk("b2b_gap", 32'(t4[15] - t4[0]), 32'd15);
    sta  = 32'h0C0C_6060;
    mism = 0;
    for (int i = 0; i < q1.size() && i < 32; i++)
      if (q1[i] !== sta[31 - i]) mism++;
    chk("busy_start_strobes1", 32'(q1.size()), 32'd32);
    chk("busy_start_data1_bad_chips", 32'(mism), 32'd0);
    chk("busy_start_eofs1", 32'(eof1_n), 32'd1);

    // Abort after five PA groups, coincident with a chip_en.
    clear_mon();
    flag_sel = 2'b01;
    pa_reps  = 5'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) en_tick();
    chk("abort_pre_busy4", 32'(bus4.busy), 32'd1);
    abort   = 1'b1;
    chip_en = 1'b1;
    tick();
    abort   = 1'b0;
    chip_en = 1'b0;
    chk("abort_out4", {25'd0, bus4.busy, bus4.chip_stb, bus4.eof, bus4.chips_o}, 32'd0);
    chk("abort_out1", {28'd0, bus1.busy, bus1.chip_stb, bus1.eof, bus1.chips_o}, 32'd0);
    en_tick();
    en_tick();
    chk("abort_strobes4", 32'(q4.size()), 32'd5);
    chk("abort_eofs", 32'(eof4_n + eof1_n), 32'd0);

    // Abort together with start in IDLE drops the start.
    flag_sel = 2'b10;
    start    = 1'b1;
    abort    = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", {30'd0, bus1.busy, bus4.busy}, 32'd0);
    en_tick();
    en_tick();
    chk("abort_start_strobes4", 32'(q4.size()), 32'd5);

    // Asynchronous reset in the middle of STO.
    clear_mon();
    flag_sel = 2'b11;
    start    = 1'b1;
    tick();
    start = 1'b0;
    en_tick();
    en_tick();
    chk("rst_pre_chips4", 32'(bus4.chips_o), 32'h0000_000C);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("rst_mid_out1", {28'd0, bus1.busy, bus1.chip_stb, bus1.eof, bus1.chips_o}, 32'd0);
    chk("rst_mid_out4", {25'd0, bus4.busy, bus4.chip_stb, bus4.eof, bus4.chips_o}, 32'd0);
    tick();
    tick();
    wb_rst_i = 1'b0;
    tick();
    run_vec(7, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
